// File: rtl/memory_n_to_1_arbiter.sv
// Shares one single-port RAM among NUM_CH clients, each with a private window of SINGLE_MEM_DEPTH words.
// Latency: grant is combinational; read data and its one-hot tag appear one cycle after the grant.
// Backpressure: requesters hold until granted, and responses cannot be stalled. ROUND_ROBIN_EN selects rotating priority.
module memory_n_to_1_arbiter #(
    parameter int WIDTH            = 32,
    parameter int NUM_CH           = 3,
    parameter int SINGLE_MEM_DEPTH = 14,
    parameter int SINGLE_DEPTH_LOG = (SINGLE_MEM_DEPTH > 1) ? $clog2(SINGLE_MEM_DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  req,
    input  logic [NUM_CH-1:0]                  req_wr,
    input  logic [NUM_CH*SINGLE_DEPTH_LOG-1:0] req_addr,
    input  logic [NUM_CH*WIDTH-1:0]            req_din,
    output logic [NUM_CH-1:0]                  gnt,
    output logic [NUM_CH-1:0]                  rsp_valid,
    output logic [WIDTH-1:0]                   rsp_dout,
    output logic [NUM_CH-1:0]                  addr_err
);

    localparam int FULL_MEM_DEPTH = NUM_CH * SINGLE_MEM_DEPTH;
    localparam int FULL_DEPTH_LOG = (FULL_MEM_DEPTH > 1) ? $clog2(FULL_MEM_DEPTH) : 1;
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [WIDTH-1:0]            mem [FULL_MEM_DEPTH];
    logic [WIDTH-1:0]            q_q;
    logic [FULL_DEPTH_LOG-1:0]   addr_q, addr_d;
    logic [NUM_CH-1:0]           rsp_valid_q, rsp_valid_d;
    logic [NUM_CH-1:0]           addr_err_q, addr_err_d;
    logic                        gnt_any;
    logic [CH_W-1:0]             gnt_ch;
    logic [SINGLE_DEPTH_LOG-1:0] local_addr;
    logic                        oor;
    logic                        wr_en;
    logic [WIDTH-1:0]            wdata;

`ifdef ROUND_ROBIN_EN
    logic [CH_W-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && req[(int'(ptr_q) + i) % NUM_CH]) begin
                gnt_any = 1'b1;
                gnt_ch  = CH_W'((int'(ptr_q) + i) % NUM_CH);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && req[i]) begin
                gnt_any = 1'b1;
                gnt_ch  = CH_W'(i);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end
`endif

    always_comb begin
        local_addr  = req_addr[gnt_ch*SINGLE_DEPTH_LOG +: SINGLE_DEPTH_LOG];
        wdata       = req_din[gnt_ch*WIDTH +: WIDTH];
        oor         = int'(local_addr) >= SINGLE_MEM_DEPTH;
        gnt         = gnt_any ? (NUM_CH'(1) << gnt_ch) : '0;
        addr_d      = addr_q;
        wr_en       = 1'b0;
        rsp_valid_d = '0;
        addr_err_d  = '0;
        if (gnt_any) begin
            addr_d = FULL_DEPTH_LOG'(int'(gnt_ch) * SINGLE_MEM_DEPTH) + FULL_DEPTH_LOG'(local_addr);
            wr_en  = req_wr[gnt_ch] && !oor;
            if (!req_wr[gnt_ch]) begin
                rsp_valid_d = gnt;
            end
            if (oor) begin
                addr_err_d = gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rsp_valid_q <= '0;
            addr_err_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Out-of-range local addresses can map past the physical array; never index it there.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_d] <= wdata;
        end
        if (int'(addr_d) < FULL_MEM_DEPTH) begin
            q_q <= mem[addr_d];
        end else begin
            q_q <= '0;
        end
    end

    // A flagged access forces zero data; the squash keeps a pre-reset response from leaking.
    assign rsp_valid = rst ? '0 : rsp_valid_q;
    assign addr_err  = rst ? '0 : addr_err_q;
    assign rsp_dout  = (|addr_err_q) ? '0 : q_q;

endmodule

// File: tb/tb_memory_n_to_1_arbiter.sv
// Randomized and directed bench for memory_n_to_1_arbiter with a transaction-level reference model.
module tb_memory_n_to_1_arbiter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int D  = 14;
    localparam int AL = 4;
    localparam int FD = N * D;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_wr;
    logic [N*AL-1:0] req_addr;
    logic [N*W-1:0]  req_din;
    logic [N-1:0]    gnt, rsp_valid, addr_err;
    logic [W-1:0]    rsp_dout;

    memory_n_to_1_arbiter #(.WIDTH(W), .NUM_CH(N), .SINGLE_MEM_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: memory image, rotation pointer, response expected next cycle.
    logic [W-1:0] m_mem [FD];
    bit           m_known [FD];
    int           m_ptr = 0;
    logic [N-1:0] e_rsp = '0;
    logic [N-1:0] e_err = '0;
    logic [W-1:0] e_dat = '0;
    bit           e_dat_known = 1'b0;

    function automatic logic [N*AL-1:0] pa(input int a0, input int a1, input int a2);
        return {AL'(a2), AL'(a1), AL'(a0)};
    endfunction

    function automatic logic [N*W-1:0] pd(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
        return {d2, d1, d0};
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model, move past the rising edge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] wr,
                        input logic [N*AL-1:0] ad, input logic [N*W-1:0] dn, output int win);
        int best, a, phys;
        rst = r; req = rq; req_wr = wr; req_addr = ad; req_din = dn;
        win = -1;
        if (!r) begin
`ifdef ROUND_ROBIN_EN
            best = N;
            for (int c = 0; c < N; c++) begin
                if (rq[c] && ((c - m_ptr + N) % N) < best) begin
                    best = (c - m_ptr + N) % N;
                    win  = c;
                end
            end
`else
            for (int c = N - 1; c >= 0; c--) begin
                if (rq[c]) win = c;
            end
`endif
        end
        @(negedge clk);
        chk("gnt", 32'(gnt), (win < 0) ? 32'd0 : (32'd1 << win));
        chk("rsp_valid", 32'(rsp_valid), r ? 32'd0 : 32'(e_rsp));
        chk("addr_err", 32'(addr_err), r ? 32'd0 : 32'(e_err));
        if (!r && e_rsp != '0 && e_dat_known) begin
            chk("rsp_dout", rsp_dout, e_dat);
        end
        e_rsp = '0;
        e_err = '0;
        if (r) begin
            m_ptr = 0;
        end else if (win >= 0) begin
            a     = int'(ad[win*AL +: AL]);
            m_ptr = (win + 1) % N;
            if (a >= D) begin
                e_err[win] = 1'b1;
                if (!wr[win]) begin
                    e_rsp[win]  = 1'b1;
                    e_dat       = '0;
                    e_dat_known = 1'b1;
                end
            end else begin
                phys = win * D + a;
                if (wr[win]) begin
                    m_mem[phys]   = dn[win*W +: W];
                    m_known[phys] = 1'b1;
                end else begin
                    e_rsp[win]  = 1'b1;
                    e_dat       = m_mem[phys];
                    e_dat_known = m_known[phys];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    bit           p_act [N];
    bit           p_wr  [N];
    int           p_a   [N];
    logic [W-1:0] p_d   [N];

    initial begin
        int win;
        int exp_order [4];
        logic [N-1:0]    rq, wr;
        logic [N*AL-1:0] ad;
        logic [N*W-1:0]  dn;
        logic            r;

        for (int i = 0; i < FD; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        for (int c = 0; c < N; c++) p_act[c] = 1'b0;

        step(1'b1, 3'b111, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        step(1'b1, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);

        step(1'b0, 3'b001, 3'b001, pa(0, 0, 0),  pd(32'h11, 0, 0), win);
        step(1'b0, 3'b010, 3'b010, pa(0, 0, 0),  pd(0, 32'h22, 0), win);
        step(1'b0, 3'b100, 3'b100, pa(0, 0, 13), pd(0, 0, 32'h33), win);

        step(1'b0, 3'b010, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        chk("rd_ch1_win", 32'(win), 32'd1);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);

        step(1'b1, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
`ifdef ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'b111, 3'b000, pa(0, 0, 13), pd(0, 0, 0), win);
            chk("all_rd_order", 32'(win), 32'(exp_order[k]));
        end

        step(1'b0, 3'b100, 3'b100, pa(0, 0, 14), pd(0, 0, 32'hFF), win);
        chk("oor_wr_win", 32'(win), 32'd2);
        step(1'b0, 3'b100, 3'b000, pa(0, 0, 13), pd(0, 0, 0), win);
        step(1'b0, 3'b010, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b001, 3'b000, pa(14, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);

        step(1'b0, 3'b001, 3'b001, pa(5, 0, 0), pd(32'hAB, 0, 0), win);
        step(1'b0, 3'b001, 3'b000, pa(5, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);

        step(1'b0, 3'b001, 3'b000, pa(5, 0, 0), pd(0, 0, 0), win);
        step(1'b1, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);
        step(1'b0, 3'b111, 3'b000, pa(1, 1, 1), pd(0, 0, 0), win);
        chk("first_gnt_after_rst", 32'(win), 32'd0);
        step(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), win);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!p_act[c] && $urandom_range(1, 0) == 1) begin
                    p_act[c] = 1'b1;
                    p_wr[c]  = ($urandom_range(1, 0) == 1);
                    p_a[c]   = $urandom_range(15, 0);
                    p_d[c]   = $urandom;
                end
            end
            for (int c = 0; c < N; c++) begin
                rq[c]          = p_act[c];
                wr[c]          = p_wr[c];
                ad[c*AL +: AL] = AL'(p_a[c]);
                dn[c*W +: W]   = p_d[c];
            end
            r = ($urandom_range(149, 0) == 0);
            step(r, rq, wr, ad, dn, win);
            if (win >= 0) p_act[win] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
